seq_alu: RTL and testbench



---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 175 +++++++++++++++++
 tb/tb_seq_alu.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the register-file read stage and seq_alu.
interface seq_alu_if #(
    parameter int N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   ALUctr;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Result;
    logic [N-1:0] Hi;
    logic         Zero;
    logic         Overflow;
    logic         DivZero;

    modport master (
        output in_valid, A, B, ALUctr, out_ready,
        input  in_ready, out_valid, Result, Hi, Zero, Overflow, DivZero
    );

    modport slave (
        input  in_valid, A, B, ALUctr, out_ready,
        output in_ready, out_valid, Result, Hi, Zero, Overflow, DivZero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned mulu/divu.
// Latency: 1 cycle for simple ops and divu-by-zero, N+1 cycles for mulu/divu.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready.
module seq_alu #(
    parameter int N = 32
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [N-1:0]   result_q;
    logic [N-1:0]   hi_q;
    logic           zero_q;
    logic           ovf_q;
    logic           dz_q;
    logic [CW-1:0]  cnt;
    logic           is_mul;
    logic [N-1:0]   opa;
    logic [N-1:0]   opb;
    logic [2*N-1:0] prod;

    // Single-cycle datapath, evaluated straight off the interface inputs.
    logic [N-1:0] sum;
    logic [N:0]   diff;
    logic         ovf_add;
    logic         ovf_sub;
    logic         less_s;
    logic [N-1:0] alu_res;
    logic [N-1:0] alu_hi;
    logic         alu_ovf;
    logic         alu_dz;
    logic         alu_multi;

    assign sum     = bus.A + bus.B;
    assign diff    = {1'b0, bus.A} - {1'b0, bus.B};
    assign ovf_add = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);
    assign ovf_sub = (bus.A[N-1] != bus.B[N-1]) && (diff[N-1] != bus.A[N-1]);
    assign less_s  = diff[N-1] ^ ovf_sub;

    always_comb begin
        alu_res   = '0;
        alu_hi    = '0;
        alu_ovf   = 1'b0;
        alu_dz    = 1'b0;
        alu_multi = 1'b0;
        case (bus.ALUctr)
            4'b0000: alu_res = sum;
            4'b0001: begin
                alu_res = sum;
                alu_ovf = ovf_add;
            end
            4'b0010: alu_res = bus.A | bus.B;
            4'b0011: alu_res = bus.A & bus.B;
            4'b0100: alu_res = diff[N-1:0];
            4'b0101: begin
                alu_res = diff[N-1:0];
                alu_ovf = ovf_sub;
            end
            4'b0110: alu_res = {{(N-1){1'b0}}, diff[N]};
            4'b0111: alu_res = {{(N-1){1'b0}}, less_s};
            4'b1000: alu_res = bus.A ^ bus.B;
            4'b1001: alu_res = ~(bus.A | bus.B);
            4'b1010: alu_multi = 1'b1;
            4'b1011: begin
                if (bus.B == '0) begin
                    alu_res = '1;
                    alu_hi  = bus.A;
                    alu_dz  = 1'b1;
                end else begin
                    alu_multi = 1'b1;
                end
            end
            default: alu_res = '0;
        endcase
    end

    // prod holds {acc, multiplier} for mulu and {remainder, dividend/quotient} for divu,
    // so both leave Result in the low half and Hi in the high half.
    logic [N:0]     mul_sum;
    logic [N:0]     div_trial;
    logic [2*N-1:0] calc_nxt;

    always_comb begin
        mul_sum   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, opa} : '0);
        div_trial = {prod[2*N-1:N], prod[N-1]} - {1'b0, opb};
        calc_nxt  = '0;
        if (is_mul) begin
            calc_nxt = {mul_sum, prod[N-1:1]};
        end else if (!div_trial[N]) begin
            calc_nxt = {div_trial[N-1:0], prod[N-2:0], 1'b1};
        end else begin
            calc_nxt = {prod[2*N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            cnt         <= '0;
            is_mul      <= 1'b0;
            opa         <= '0;
            opb         <= '0;
            prod        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (alu_multi) begin
                            state  <= CALC;
                            cnt    <= '0;
                            is_mul <= (bus.ALUctr == 4'b1010);
                            opa    <= bus.A;
                            opb    <= bus.B;
                            prod   <= (bus.ALUctr == 4'b1010) ? {{N{1'b0}}, bus.B}
                                                              : {{N{1'b0}}, bus.A};
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            hi_q        <= alu_hi;
                            zero_q      <= (alu_res == '0);
                            ovf_q       <= alu_ovf;
                            dz_q        <= alu_dz;
                        end
                    end
                end
                CALC: begin
                    prod <= calc_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= calc_nxt[N-1:0];
                        hi_q        <= calc_nxt[2*N-1:N];
                        zero_q      <= (calc_nxt[N-1:0] == '0);
                        ovf_q       <= 1'b0;
                        dz_q        <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Hi        = hi_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.DivZero   = dz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at N=32 (vector table + hand sequences) and N=8 (mulu/divu).
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.N(32)) b32 ();
    seq_alu_if #(.N(8))  b8 ();

    seq_alu #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    seq_alu #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit stall_bad);
        b32.A = a; b32.B = b; b32.ALUctr = op; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        b32.A = $urandom; b32.B = $urandom; b32.ALUctr = 4'($urandom);
        lat = 1;
        stall_bad = 1'b0;
        while (!b32.out_valid && lat < 100) begin
            if (b32.in_ready) stall_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit stall_bad);
        b8.A = a; b8.B = b; b8.ALUctr = op; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        b8.A = 8'($urandom); b8.B = 8'($urandom);
        lat = 1;
        stall_bad = 1'b0;
        while (!b8.out_valid && lat < 100) begin
            if (b8.in_ready) stall_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release32();
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
    endtask

    task automatic release8();
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  sb;
        bit  saw;
        vec_t v;

        //                  op       A             B             Result        Hi            Z     Ovf   DZ   lat
        vecs.push_back('{4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0101, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b1011, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b1011, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{4'b0101, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0100, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0010, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0110, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1100, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1010, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b1011, 32'd7,        32'd100,      32'd0,        32'd7,        1'b1, 1'b0, 1'b0, 33});

        rst = 1'b1;
        b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.A = '0; b32.B = '0; b32.ALUctr = '0;
        b8.in_valid  = 1'b0; b8.out_ready  = 1'b0; b8.A  = '0; b8.B  = '0; b8.ALUctr  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready",  32'(b32.in_ready),  32'd1);
        chk("rst out_valid", 32'(b32.out_valid), 32'd0);
        chk("rst Result",    b32.Result,         32'd0);
        chk("rst Hi",        b32.Hi,             32'd0);
        chk("rst flags",     {29'd0, b32.Zero, b32.Overflow, b32.DivZero}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            chk($sformatf("v%0d in_ready", i), 32'(b32.in_ready), 32'd1);
            run32(v.op, v.a, v.b, lat, sb);
            chk($sformatf("v%0d latency", i),  32'(lat),            32'(v.lat));
            chk($sformatf("v%0d Result", i),   b32.Result,          v.res);
            chk($sformatf("v%0d Hi", i),       b32.Hi,              v.hi);
            chk($sformatf("v%0d Zero", i),     32'(b32.Zero),       32'(v.z));
            chk($sformatf("v%0d Overflow", i), 32'(b32.Overflow),   32'(v.ovf));
            chk($sformatf("v%0d DivZero", i),  32'(b32.DivZero),    32'(v.dz));
            chk($sformatf("v%0d in_ready busy", i), 32'(sb),        32'd0);
            release32();
            chk($sformatf("v%0d out_valid drop", i), 32'(b32.out_valid), 32'd0);
        end

        // Result held in DONE under backpressure while a new op is waiting upstream.
        run32(4'b0001, 32'd2, 32'd3, lat, sb);
        b32.in_valid = 1'b1; b32.A = 32'd7; b32.B = 32'd7; b32.ALUctr = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d Result", k),    b32.Result,         32'd5);
            chk($sformatf("hold%0d out_valid", k), 32'(b32.out_valid), 32'd1);
            chk($sformatf("hold%0d in_ready", k),  32'(b32.in_ready),  32'd0);
        end
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b0;
        chk("hold exit in_ready",  32'(b32.in_ready),  32'd1);
        chk("hold exit out_valid", 32'(b32.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("hold no accept", 32'(b32.out_valid), 32'd0);

        // Reset during the 10th CALC cycle of a mulu.
        b32.A = 32'hFFFFFFFF; b32.B = 32'hFFFFFFFF; b32.ALUctr = 4'b1010; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort in_ready",  32'(b32.in_ready),  32'd1);
        chk("abort out_valid", 32'(b32.out_valid), 32'd0);
        chk("abort Result",    b32.Result,         32'd0);
        chk("abort Hi",        b32.Hi,             32'd0);
        chk("abort flags",     {29'd0, b32.Zero, b32.Overflow, b32.DivZero}, 32'd0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (b32.out_valid) saw = 1'b1;
        end
        chk("abort no result", 32'(saw), 32'd0);
        run32(4'b0001, 32'd2, 32'd3, lat, sb);
        chk("post-abort add latency", 32'(lat), 32'd1);
        chk("post-abort add Result",  b32.Result, 32'd5);
        release32();

        // N=8 instance.
        chk("n8 in_ready", 32'(b8.in_ready), 32'd1);
        run8(4'b1010, 8'hFF, 8'hFF, lat, sb);
        chk("n8 mulu latency", 32'(lat),       32'd9);
        chk("n8 mulu Result",  32'(b8.Result), 32'h01);
        chk("n8 mulu Hi",      32'(b8.Hi),     32'hFE);
        chk("n8 mulu Zero",    32'(b8.Zero),   32'd0);
        chk("n8 mulu stall",   32'(sb),        32'd0);
        release8();
        run8(4'b1011, 8'd200, 8'd7, lat, sb);
        chk("n8 divu latency", 32'(lat),       32'd9);
        chk("n8 divu Result",  32'(b8.Result), 32'd28);
        chk("n8 divu Hi",      32'(b8.Hi),     32'd4);
        release8();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
